up_counter_mmss: RTL and testbench

- Four-digit mm:ss up-counting stopwatch, 00:00 to 59:59.
- Counterpart of the minute/second down-counter chain: digits ripple a carry upward where the countdown ripples a borrow downward.
- Sits between the debounced push-button/FSM front end and the 7-segment scan driver.
- Advances on a one-cycle count-enable tick; holds start/pause/lap state in an internal FSM.

---
 rtl/up_counter_mmss_pkg.sv | 24 ++
 rtl/up_counter_digit.sv | 35 +++
 rtl/up_counter_mmss.sv | 188 ++++++++++++++++++
 tb/tb_up_counter_mmss.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/up_counter_mmss_pkg.sv
// Shared constants for the mm:ss up-counter: digit terminal values, BCD width, FSM encoding.
// Pure declarations; no clocked logic, no flow control.
package up_counter_mmss_pkg;

    localparam int DIGIT_W = 4;

    localparam int SEC_LO_MAX_DEF = 9;
    localparam int SEC_HI_MAX_DEF = 5;
    localparam int MIN_LO_MAX_DEF = 9;
    localparam int MIN_HI_MAX_DEF = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_LAP   = 3'd3;
    localparam logic [2:0] ST_FULL  = 3'd4;

    // Out-of-range preset digits saturate at the digit's terminal value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                       input logic [DIGIT_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/up_counter_digit.sv
// One BCD digit of the carry chain: counts 0..MAX, q registered (1-cycle latency).
// No backpressure; cout is combinational "at terminal" and feeds the next digit's enable.
module up_counter_digit
    import up_counter_mmss_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk_d,
    input  logic               rst,
    input  logic               cin_en,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] q,
    output logic               cout
);

    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);

    assign cout = (q == MAX_D);

    // clr beats load beats increment, matching the top-level input priority.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= clamp_digit(load_val, MAX_D);
        end else if (cin_en) begin
            q <= cout ? '0 : q + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/up_counter_mmss.sv
// mm:ss stopwatch 00:00..59:59 with run/pause/lap FSM; tick-to-disp latency 1 cycle, no backpressure.
// Default saturates in FULL at 59:59; define UP_COUNTER_WRAP_EN to wrap to 00:00 instead.
module up_counter_mmss
    import up_counter_mmss_pkg::*;
#(
    parameter int SEC_LO_MAX = SEC_LO_MAX_DEF,
    parameter int SEC_HI_MAX = SEC_HI_MAX_DEF,
    parameter int MIN_LO_MAX = MIN_LO_MAX_DEF,
    parameter int MIN_HI_MAX = MIN_HI_MAX_DEF
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clr,
    input  logic        lap,
    input  logic        set_en,
    input  logic [15:0] set_val,
    output logic [15:0] disp,
    output logic        running,
    output logic        full,
    output logic        co_out
);

    logic [2:0]  state_q;
    logic [2:0]  state_nxt;

    logic        counting;
    logic        load_ok;
    logic        show_lap;

    logic [DIGIT_W-1:0] s0_q, s1_q, m0_q, m1_q;
    logic        c0, c1, c2, c3;
    logic        en0, en1, en2, en3;
    logic [15:0] count;
    logic [15:0] lap_q;
    logic        at_max;
    logic        step;
    logic        load;
    logic        term_hit;
    logic        sat_hit;

    assign count  = {m1_q, m0_q, s1_q, s0_q};
    assign at_max = c0 & c1 & c2 & c3;
    assign step   = tick & counting & ~clr;
    assign load   = set_en & load_ok & ~clr & ~start_stop;

`ifdef UP_COUNTER_WRAP_EN
    assign en0      = step;
    assign term_hit = step & at_max;
    assign sat_hit  = 1'b0;
`else
    logic pre_max;
    // One tick short of 59:59: this tick lands on terminal and the FSM parks in FULL.
    assign pre_max  = c1 & c2 & c3 & (s0_q == DIGIT_W'(SEC_LO_MAX - 1));
    assign en0      = step & ~at_max;
    assign term_hit = step & (at_max | pre_max);
    assign sat_hit  = term_hit;
`endif

    assign en1 = en0 & c0;
    assign en2 = en1 & c1;
    assign en3 = en2 & c2;

    up_counter_digit #(.MAX(SEC_LO_MAX)) u_sec_lo (
        .clk_d    (clk_d),
        .rst      (rst),
        .cin_en   (en0),
        .clr      (clr),
        .load     (load),
        .load_val (set_val[3:0]),
        .q        (s0_q),
        .cout     (c0)
    );

    up_counter_digit #(.MAX(SEC_HI_MAX)) u_sec_hi (
        .clk_d    (clk_d),
        .rst      (rst),
        .cin_en   (en1),
        .clr      (clr),
        .load     (load),
        .load_val (set_val[7:4]),
        .q        (s1_q),
        .cout     (c1)
    );

    up_counter_digit #(.MAX(MIN_LO_MAX)) u_min_lo (
        .clk_d    (clk_d),
        .rst      (rst),
        .cin_en   (en2),
        .clr      (clr),
        .load     (load),
        .load_val (set_val[11:8]),
        .q        (m0_q),
        .cout     (c2)
    );

    up_counter_digit #(.MAX(MIN_HI_MAX)) u_min_hi (
        .clk_d    (clk_d),
        .rst      (rst),
        .cin_en   (en3),
        .clr      (clr),
        .load     (load),
        .load_val (set_val[15:12]),
        .q        (m1_q),
        .cout     (c3)
    );

    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Priority: clr > start_stop > lap > tick-driven terminal transition.
    always_comb begin
        state_nxt = state_q;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (start_stop)   state_nxt = ST_PAUSE;
                    else if (lap)     state_nxt = ST_LAP;
                    else if (sat_hit) state_nxt = ST_FULL;
                end
                ST_LAP: begin
                    if (start_stop)   state_nxt = ST_PAUSE;
                    else if (lap)     state_nxt = ST_RUN;
                    else if (sat_hit) state_nxt = ST_FULL;
                end
                ST_PAUSE: begin
                    if (start_stop) state_nxt = ST_RUN;
                end
                ST_FULL: begin
                    state_nxt = ST_FULL;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        counting = 1'b0;
        load_ok  = 1'b0;
        show_lap = 1'b0;
        running  = 1'b0;
        full     = 1'b0;
        case (state_q)
            ST_IDLE:  load_ok = 1'b1;
            ST_PAUSE: load_ok = 1'b1;
            ST_RUN: begin
                counting = 1'b1;
                running  = 1'b1;
            end
            ST_LAP: begin
                counting = 1'b1;
                running  = 1'b1;
                show_lap = 1'b1;
            end
            ST_FULL:  full = 1'b1;
            default: ;
        endcase
    end

    // Lap snapshot is the pre-tick count of the cycle the lap pulse arrives in RUN.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            lap_q  <= '0;
            co_out <= 1'b0;
        end else begin
            co_out <= term_hit;
            if (clr) begin
                lap_q <= '0;
            end else if ((state_q == ST_RUN) && lap && !start_stop) begin
                lap_q <= count;
            end
        end
    end

    assign disp = show_lap ? lap_q : count;

endmodule

// File: tb/tb_up_counter_mmss.sv
module tb_up_counter_mmss;

    logic        clk_d = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        clr = 1'b0;
    logic        lap = 1'b0;
    logic        set_en = 1'b0;
    logic [15:0] set_val = 16'h0000;
    logic [15:0] disp;
    logic        running;
    logic        full;
    logic        co_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    up_counter_mmss dut (
        .clk_d      (clk_d),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .clr        (clr),
        .lap        (lap),
        .set_en     (set_en),
        .set_val    (set_val),
        .disp       (disp),
        .running    (running),
        .full       (full),
        .co_out     (co_out)
    );

    always #5 clk_d = ~clk_d;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Drive one cycle of inputs from a falling edge; returns at the next falling edge.
    task automatic step(input logic t, input logic ss, input logic c, input logic l,
                        input logic se, input logic [15:0] sv);
        tick = t; start_stop = ss; clr = c; lap = l; set_en = se; set_val = sv;
        @(negedge clk_d);
        tick = 1'b0; start_stop = 1'b0; clr = 1'b0; lap = 1'b0; set_en = 1'b0; set_val = 16'h0000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk_d);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp: got %h want 0000", disp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (co_out !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", co_out); end
        rst = 1'b0;
        @(negedge clk_d);
    endtask

    task automatic test_count;
        int model;
        int co_seen;
        logic [15:0] e;
        model = 0;
        co_seen = 0;
        step(0, 1, 0, 0, 0, 16'h0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL count_running: got %b want 1", running); end
        for (int i = 0; i < 75; i++) begin
            model++;
            exp_q.push_back(to_bcd(model));
            step(1, 0, 0, 0, 0, 16'h0);
            if (co_out !== 1'b0) co_seen++;
            e = exp_q.pop_front();
            checks++; if (disp !== e) begin errors++; $display("FAIL count_tick%0d: got %h want %h", i, disp, e); end
            if (i % 4 == 0) step(0, 0, 0, 0, 0, 16'h0);
        end
        checks++; if (disp !== 16'h0115) begin errors++; $display("FAIL count_final: got %h want 0115", disp); end
        checks++; if (co_seen !== 0) begin errors++; $display("FAIL count_co: got %0d pulses want 0", co_seen); end
        step(0, 0, 1, 0, 0, 16'h0);
    endtask

    task automatic test_full;
        int co_seen;
        logic [15:0] e;
        logic exp_full;
        co_seen = 0;
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h5958);
        checks++; if (disp !== 16'h5958) begin errors++; $display("FAIL full_preset: got %h want 5958", disp); end
        step(0, 1, 0, 0, 0, 16'h0);
        exp_q.push_back(16'h5959);
`ifdef UP_COUNTER_WRAP_EN
        exp_q.push_back(16'h0000);
        exp_full = 1'b0;
`else
        exp_q.push_back(16'h5959);
        exp_full = 1'b1;
`endif
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 16'h0);
            if (co_out === 1'b1) co_seen++;
            e = exp_q.pop_front();
            checks++; if (disp !== e) begin errors++; $display("FAIL full_tick%0d: got %h want %h", i, disp, e); end
        end
        checks++; if (full !== exp_full) begin errors++; $display("FAIL full_flag: got %b want %b", full, exp_full); end
        step(0, 1, 0, 0, 0, 16'h0);
        checks++; if (full !== exp_full) begin errors++; $display("FAIL full_ss_ignored: got %b want %b", full, exp_full); end
        e = disp;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, 16'h0);
            if (co_out === 1'b1) co_seen++;
        end
`ifdef UP_COUNTER_WRAP_EN
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL full_hold: got %h want 0000", disp); end
`else
        checks++; if (disp !== 16'h5959) begin errors++; $display("FAIL full_hold: got %h want 5959", disp); end
`endif
        checks++; if (co_seen !== 1) begin errors++; $display("FAIL full_co: got %0d pulses want 1", co_seen); end
        step(0, 0, 1, 0, 0, 16'h0);
    endtask

    task automatic test_lap;
        logic [15:0] e;
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0009);
        step(0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 0, 16'h0);
        checks++; if (disp !== 16'h0009) begin errors++; $display("FAIL lap_capture: got %h want 0009", disp); end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'h0009);
            step(1, 0, 0, 0, 0, 16'h0);
            e = exp_q.pop_front();
            checks++; if (disp !== e) begin errors++; $display("FAIL lap_hold%0d: got %h want %h", i, disp, e); end
        end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running: got %b want 1", running); end
        step(0, 0, 0, 1, 0, 16'h0);
        checks++; if (disp !== 16'h0014) begin errors++; $display("FAIL lap_release: got %h want 0014", disp); end
    endtask

    task automatic test_pause_tick;
        logic [15:0] e;
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0030);
        step(0, 1, 0, 0, 0, 16'h0);
        exp_q.push_back(16'h0031);
        step(1, 1, 0, 0, 0, 16'h0);
        e = exp_q.pop_front();
        checks++; if (disp !== e) begin errors++; $display("FAIL pause_tick: got %h want %h", disp, e); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h0031);
            step(1, 0, 0, 0, 0, 16'h0);
            e = exp_q.pop_front();
            checks++; if (disp !== e) begin errors++; $display("FAIL pause_ignore%0d: got %h want %h", i, disp, e); end
        end
    endtask

    task automatic test_clr_priority;
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h1234);
        step(0, 1, 0, 0, 0, 16'h0);
        checks++; if (disp !== 16'h1234) begin errors++; $display("FAIL clr_preset: got %h want 1234", disp); end
        step(1, 1, 1, 0, 0, 16'h0);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clr_disp: got %h want 0000", disp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL clr_running: got %b want 0", running); end
        step(1, 0, 0, 0, 0, 16'h0);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clr_idle_tick: got %h want 0000", disp); end
        step(0, 1, 0, 0, 0, 16'h0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL clr_idle_start: got %b want 1", running); end
    endtask

    task automatic test_clamp_async;
        logic [15:0] e;
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h7A9F);
        checks++; if (disp !== 16'h5959) begin errors++; $display("FAIL clamp: got %h want 5959", disp); end
        step(0, 0, 0, 0, 1, 16'h0102);
        checks++; if (disp !== 16'h0102) begin errors++; $display("FAIL pause_load: got %h want 0102", disp); end
        step(0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0300);
        checks++; if (disp !== 16'h0102) begin errors++; $display("FAIL run_load_ignored: got %h want 0102", disp); end
        exp_q.push_back(16'h0103);
        step(1, 0, 0, 0, 0, 16'h0);
        e = exp_q.pop_front();
        checks++; if (disp !== e) begin errors++; $display("FAIL run_tick: got %h want %h", disp, e); end
        #2 rst = 1'b1;
        #1;
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL async_disp: got %h want 0000", disp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_running: got %b want 0", running); end
        checks++; if (full !== 1'b0 || co_out !== 1'b0) begin errors++; $display("FAIL async_flags: got full=%b co=%b want 0 0", full, co_out); end
        @(negedge clk_d);
        rst = 1'b0;
        @(negedge clk_d);
    endtask

    initial begin
        test_reset();
        test_count();
        test_full();
        test_lap();
        test_pause_tick();
        test_clr_priority();
        test_clamp_async();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
